trap_monitor: RTL and testbench

TRAP_MONITOR -- requirements
Module: trap_monitor

---
 rtl/trap_monitor.sv | 151 +++++++++++++++
 tb/tb_trap_monitor.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/trap_monitor.sv
// Simulation trap monitor: watches retiring instructions for ebreak, illegal or watchdog expiry and sequences RUN -> DRAIN -> DONE.
// Trap fields are registered one cycle after the trapping commit; there is no backpressure, and commits after a trap are ignored.
module trap_monitor #(
   parameter int XLEN         = 64,
   parameter int DRAIN_CYCLES = 4,
   parameter int WDOG_LIMIT   = 1000000,
   parameter int WDOG_W       = 32
) (
   input  logic            i_clock,
   input  logic            i_reset_n,
   input  logic            i_commit_valid,
   input  logic [31:0]     i_commit_inst,
   input  logic [XLEN-1:0] i_commit_pc,
   input  logic            i_commit_illegal,
   input  logic [XLEN-1:0] i_a0,
   output logic            o_halt,
   output logic [1:0]      o_halt_cause,
   output logic            o_good_trap,
   output logic [XLEN-1:0] o_exit_code,
   output logic [XLEN-1:0] o_halt_pc,
   output logic            o_sim_finish,
   output logic [63:0]     o_cycle_cnt,
   output logic [63:0]     o_instret_cnt
);

   localparam logic [31:0]       EBREAK     = 32'h00100073;
   localparam int                DCW        = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DCW-1:0]    DRAIN_LOAD = (DRAIN_CYCLES > 0) ? DCW'(DRAIN_CYCLES - 1) : '0;
   localparam logic [WDOG_W-1:0] WDOG_MAX   = (WDOG_LIMIT > 0) ? WDOG_W'(WDOG_LIMIT - 1) : '0;
   localparam logic              WDOG_EN    = (WDOG_LIMIT > 0);

   localparam logic [1:0] CAUSE_EBREAK  = 2'd1;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'd2;
   localparam logic [1:0] CAUSE_WDOG    = 2'd3;

   typedef enum logic [1:0] {
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t            r_state;
   logic [DCW-1:0]    r_drain_cnt;
   logic [WDOG_W-1:0] r_wdog_cnt;
   logic [XLEN-1:0]   r_last_pc;
   logic              r_halt;
   logic [1:0]        r_halt_cause;
   logic              r_good_trap;
   logic [XLEN-1:0]   r_exit_code;
   logic [XLEN-1:0]   r_halt_pc;
   logic              r_sim_finish;
   logic [63:0]       r_cycle_cnt;
   logic [63:0]       r_instret_cnt;

   logic              w_run;
   logic              w_ill_trap;
   logic              w_ebreak_trap;
   logic              w_wdog_trap;
   logic              w_trap;
   logic [1:0]        w_cause;
   logic [XLEN-1:0]   w_exit_code;
   logic [XLEN-1:0]   w_halt_pc;

   assign w_run         = (r_state == S_RUN);
   assign w_ill_trap    = w_run & i_commit_valid & i_commit_illegal;
   assign w_ebreak_trap = w_run & i_commit_valid & ~i_commit_illegal & (i_commit_inst == EBREAK);
   // A commit in the expiry cycle wins over the watchdog.
   assign w_wdog_trap   = WDOG_EN & w_run & ~i_commit_valid & (r_wdog_cnt == WDOG_MAX);
   assign w_trap        = w_ill_trap | w_ebreak_trap | w_wdog_trap;

   always_comb begin
      w_cause     = CAUSE_WDOG;
      w_exit_code = '1;
      w_halt_pc   = r_last_pc;
      if (w_ill_trap) begin
         w_cause   = CAUSE_ILLEGAL;
         w_halt_pc = i_commit_pc;
      end else if (w_ebreak_trap) begin
         w_cause     = CAUSE_EBREAK;
         w_exit_code = i_a0;
         w_halt_pc   = i_commit_pc;
      end
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state       <= S_RUN;
         r_drain_cnt   <= '0;
         r_wdog_cnt    <= '0;
         r_last_pc     <= '0;
         r_halt        <= 1'b0;
         r_halt_cause  <= 2'd0;
         r_good_trap   <= 1'b0;
         r_exit_code   <= '0;
         r_halt_pc     <= '0;
         r_sim_finish  <= 1'b0;
         r_cycle_cnt   <= '0;
         r_instret_cnt <= '0;
      end else begin
         r_sim_finish <= 1'b0;
         case (r_state)
            S_RUN: begin
               r_cycle_cnt <= r_cycle_cnt + 64'd1;
               if (i_commit_valid) begin
                  r_instret_cnt <= r_instret_cnt + 64'd1;
                  r_last_pc     <= i_commit_pc;
                  r_wdog_cnt    <= '0;
               end else if (WDOG_EN) begin
                  r_wdog_cnt <= r_wdog_cnt + WDOG_W'(1);
               end
               if (w_trap) begin
                  r_halt       <= 1'b1;
                  r_halt_cause <= w_cause;
                  r_exit_code  <= w_exit_code;
                  r_halt_pc    <= w_halt_pc;
                  r_good_trap  <= (w_cause == CAUSE_EBREAK) && (w_exit_code == '0);
                  if (DRAIN_CYCLES == 0) begin
                     r_state      <= S_DONE;
                     r_sim_finish <= 1'b1;
                  end else begin
                     r_state     <= S_DRAIN;
                     r_drain_cnt <= DRAIN_LOAD;
                  end
               end
            end
            S_DRAIN: begin
               r_cycle_cnt <= r_cycle_cnt + 64'd1;
               if (r_drain_cnt == '0) begin
                  r_state      <= S_DONE;
                  r_sim_finish <= 1'b1;
               end else begin
                  r_drain_cnt <= r_drain_cnt - DCW'(1);
               end
            end
            default: begin
               r_state <= S_DONE;
            end
         endcase
      end
   end

   assign o_halt        = r_halt;
   assign o_halt_cause  = r_halt_cause;
   assign o_good_trap   = r_good_trap;
   assign o_exit_code   = r_exit_code;
   assign o_halt_pc     = r_halt_pc;
   assign o_sim_finish  = r_sim_finish;
   assign o_cycle_cnt   = r_cycle_cnt;
   assign o_instret_cnt = r_instret_cnt;

endmodule

// File: tb/tb_trap_monitor.sv
// Bench for trap_monitor: directed and random commit streams against a trace-scanning reference model.
module tb_trap_monitor;
   localparam int          XL     = 64;
   localparam int          DR     = 4;
   localparam int          WL     = 8;
   localparam logic [31:0] EBREAK = 32'h00100073;
   localparam logic [31:0] NOP    = 32'h00000013;

   typedef struct {
      logic          v;
      logic [31:0]   inst;
      logic [XL-1:0] pc;
      logic          ill;
      logic [XL-1:0] a0;
   } cyc_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          commit_valid = 1'b0;
   logic [31:0]   commit_inst = '0;
   logic [XL-1:0] commit_pc = '0;
   logic          commit_illegal = 1'b0;
   logic [XL-1:0] a0 = '0;
   logic          halt;
   logic [1:0]    halt_cause;
   logic          good_trap;
   logic [XL-1:0] exit_code;
   logic [XL-1:0] halt_pc;
   logic          sim_finish;
   logic [63:0]   cycle_cnt;
   logic [63:0]   instret_cnt;

   always #5 clk = ~clk;

   trap_monitor #(.XLEN(XL), .DRAIN_CYCLES(DR), .WDOG_LIMIT(WL), .WDOG_W(32)) dut (
      .i_clock(clk), .i_reset_n(rst_n), .i_commit_valid(commit_valid),
      .i_commit_inst(commit_inst), .i_commit_pc(commit_pc),
      .i_commit_illegal(commit_illegal), .i_a0(a0),
      .o_halt(halt), .o_halt_cause(halt_cause), .o_good_trap(good_trap),
      .o_exit_code(exit_code), .o_halt_pc(halt_pc), .o_sim_finish(sim_finish),
      .o_cycle_cnt(cycle_cnt), .o_instret_cnt(instret_cnt)
   );

   cyc_t stim[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic cyc_t mk(input logic v, input logic [31:0] inst, input logic [XL-1:0] pc,
                               input logic ill, input logic [XL-1:0] av);
      cyc_t c;
      c.v = v; c.inst = inst; c.pc = pc; c.ill = ill; c.a0 = av;
      return c;
   endfunction

   task automatic drive(input cyc_t c);
      commit_valid   = c.v;
      commit_inst    = c.inst;
      commit_pc      = c.pc;
      commit_illegal = c.ill;
      a0             = c.a0;
   endtask

   // Scan the trace for the first trap; everything after it is ignored.
   task automatic model(output int t_idx, output logic [1:0] cause, output logic [XL-1:0] ec,
                        output logic [XL-1:0] hpc, output int ninst);
      int            idle = 0;
      logic [XL-1:0] last = '0;
      t_idx = -1; cause = 2'd0; ec = '0; hpc = '0; ninst = 0;
      foreach (stim[i]) begin
         if (t_idx < 0) begin
            if (stim[i].v) begin
               ninst++;
               idle = 0;
               last = stim[i].pc;
               if (stim[i].ill) begin
                  cause = 2'd2; ec = '1; hpc = stim[i].pc; t_idx = i;
               end else if (stim[i].inst == EBREAK) begin
                  cause = 2'd1; ec = stim[i].a0; hpc = stim[i].pc; t_idx = i;
               end
            end else begin
               idle++;
               if (idle == WL) begin
                  cause = 2'd3; ec = '1; hpc = last; t_idx = i;
               end
            end
         end
      end
   endtask

   task automatic check_reset_vals(input string name);
      check_eq({name, ".halt"}, 64'(halt), 64'd0);
      check_eq({name, ".cause"}, 64'(halt_cause), 64'd0);
      check_eq({name, ".good"}, 64'(good_trap), 64'd0);
      check_eq({name, ".exit"}, exit_code, 64'd0);
      check_eq({name, ".hpc"}, halt_pc, 64'd0);
      check_eq({name, ".fin"}, 64'(sim_finish), 64'd0);
      check_eq({name, ".cyc"}, cycle_cnt, 64'd0);
      check_eq({name, ".inst"}, instret_cnt, 64'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      drive(mk(1'b0, '0, '0, 1'b0, '0));
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   // Cycle i's inputs are captured by edge i after reset release; outputs sampled on the following negedge.
   task automatic run_scenario(input string name, input bit with_reset);
      int            t_idx, ninst, ncyc;
      int            first_halt = -1;
      int            fin_edge = -1;
      int            fin_cnt = 0;
      logic [1:0]    cause;
      logic [XL-1:0] ec, hpc;
      for (int i = 0; i < WL; i++) stim.push_back(mk(1'b0, NOP, '0, 1'b0, '0));
      model(t_idx, cause, ec, hpc, ninst);
      if (with_reset) do_reset();
      ncyc = stim.size() + DR + 3;
      for (int i = 0; i <= ncyc; i++) begin
         @(negedge clk);
         if (i > 0) begin
            if (halt && first_halt < 0) first_halt = i - 1;
            if (sim_finish) begin
               fin_cnt++;
               fin_edge = i - 1;
            end
         end
         if (i < stim.size()) drive(stim[i]);
         else drive(mk(1'b0, '0, '0, 1'b0, '0));
      end
      check_eq({name, ".halt_edge"}, 64'(first_halt), 64'(t_idx));
      check_eq({name, ".fin_edge"}, 64'(fin_edge), 64'(t_idx + DR));
      check_eq({name, ".fin_cnt"}, 64'(fin_cnt), 64'd1);
      check_eq({name, ".cause"}, 64'(halt_cause), 64'(cause));
      check_eq({name, ".exit"}, exit_code, ec);
      check_eq({name, ".hpc"}, halt_pc, hpc);
      check_eq({name, ".good"}, 64'(good_trap), 64'((cause == 2'd1) && (ec == '0)));
      check_eq({name, ".instret"}, instret_cnt, 64'(ninst));
      check_eq({name, ".cycles"}, cycle_cnt, 64'(t_idx + 1 + DR));
      stim.delete();
   endtask

   initial begin
      cyc_t c;
      #1 rst_n = 1'b0;
      #1 check_reset_vals("por");

      // Good trap after three ordinary commits.
      for (int i = 0; i < 3; i++) stim.push_back(mk(1'b1, NOP, 64'h80000004 + 64'(4 * i), 1'b0, 64'd3));
      stim.push_back(mk(1'b1, EBREAK, 64'h80000010, 1'b0, 64'd0));
      run_scenario("good", 1'b1);

      stim.push_back(mk(1'b1, EBREAK, 64'h200, 1'b0, 64'd5));
      run_scenario("bad_exit", 1'b1);

      stim.push_back(mk(1'b1, NOP, 64'h300, 1'b0, 64'd0));
      stim.push_back(mk(1'b1, EBREAK, 64'h304, 1'b1, 64'd0));
      run_scenario("illegal", 1'b1);

      stim.push_back(mk(1'b1, NOP, 64'h100, 1'b0, 64'd0));
      run_scenario("wdog", 1'b1);

      // Commit arrives in the expiry cycle, then ebreak later.
      stim.push_back(mk(1'b1, NOP, 64'h400, 1'b0, 64'd0));
      for (int i = 0; i < WL - 1; i++) stim.push_back(mk(1'b0, EBREAK, 64'h0, 1'b1, 64'd0));
      stim.push_back(mk(1'b1, NOP, 64'h404, 1'b0, 64'd0));
      stim.push_back(mk(1'b1, EBREAK, 64'h408, 1'b0, 64'd0));
      run_scenario("wdog_race", 1'b1);

      stim.push_back(mk(1'b1, EBREAK, 64'h500, 1'b0, 64'd0));
      for (int i = 0; i < 6; i++) stim.push_back(mk(1'b1, EBREAK, 64'h600 + 64'(i), 1'(i % 2), 64'd9));
      run_scenario("drain_ignore", 1'b1);

      // Reset pulse in the middle of DRAIN, then a normal trap with no extra reset.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i == 0) drive(mk(1'b1, NOP, 64'h700, 1'b0, 64'd1));
         else if (i == 1) drive(mk(1'b1, EBREAK, 64'h704, 1'b0, 64'd0));
         else drive(mk(1'b0, '0, '0, 1'b0, '0));
      end
      @(negedge clk);
      check_eq("mid_drain.halt", 64'(halt), 64'd1);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1 check_reset_vals("mid_drain_rst");
      #1 rst_n = 1'b1;
      stim.push_back(mk(1'b0, NOP, '0, 1'b0, '0));
      stim.push_back(mk(1'b1, NOP, 64'h800, 1'b0, 64'd0));
      stim.push_back(mk(1'b1, EBREAK, 64'h804, 1'b0, 64'd7));
      run_scenario("after_abort", 1'b0);

      for (int s = 0; s < 20; s++) begin
         int len = $urandom_range(5, 40);
         for (int i = 0; i < len; i++) begin
            int r = $urandom_range(0, 99);
            if (r >= 94) begin
               int n = $urandom_range(WL - 2, WL);
               for (int k = 0; k < n; k++) stim.push_back(mk(1'b0, EBREAK, '0, 1'b0, '0));
            end
            c.v    = (r < 70);
            c.inst = $urandom;
            if (c.inst == EBREAK) c.inst = NOP;
            if ($urandom_range(0, 9) < 2) c.inst = EBREAK;
            c.pc   = {$urandom, $urandom};
            c.ill  = ($urandom_range(0, 19) == 0);
            c.a0   = ($urandom_range(0, 1) == 1) ? 64'd0 : {$urandom, $urandom};
            stim.push_back(c);
         end
         run_scenario($sformatf("rnd%0d", s), 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
